// File: rtl/instruction_fetch.sv
// Fetch stage: keeps the fetch PC, reads instruction memory over a req/ack handshake, and
// fills the fetch/decode register. Optional perf counters are enabled with FETCH_PERF_CNT_EN.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] cnt_val,
  output logic [31:0] cnt_val_pl4,
  output logic        instr_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  // state | meaning
  // IDLE  | one cycle after reset
  // REQ   | request to fetch_pc outstanding
  // HOLD  | returned word parked while decode stalls
  // DRAIN | discarding data of a request killed by redirect
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic [31:0] instruction_q, instruction_d;
  logic [31:0] cnt_val_q, cnt_val_d;
  logic [31:0] cnt_val_pl4_q, cnt_val_pl4_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_pc4_q, hold_pc4_d;
  logic        hold_valid_q, hold_valid_d;
  logic        deliver;
  logic [31:0] redirect_tgt;
  logic        unused_redirect_lsb;

  assign redirect_tgt        = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign imem_req    = (state_q == S_REQ) || (state_q == S_DRAIN);
  assign imem_addr   = (state_q == S_REQ)   ? fetch_pc_q :
                       (state_q == S_DRAIN) ? drain_addr_q : 32'h0;
  assign instruction = instruction_q;
  assign cnt_val     = cnt_val_q;
  assign cnt_val_pl4 = cnt_val_pl4_q;
  assign instr_valid = instr_valid_q;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    drain_addr_d  = drain_addr_q;
    instruction_d = instruction_q;
    cnt_val_d     = cnt_val_q;
    cnt_val_pl4_d = cnt_val_pl4_q;
    instr_valid_d = instr_valid_q;
    hold_instr_d  = hold_instr_q;
    hold_pc_d     = hold_pc_q;
    hold_pc4_d    = hold_pc4_q;
    hold_valid_d  = hold_valid_q;
    deliver       = 1'b0;

    if (redirect) begin
      instr_valid_d = 1'b0;
      instruction_d = NOP_INSTR;
      hold_valid_d  = 1'b0;
      fetch_pc_d    = redirect_tgt;
      case (state_q)
        S_REQ: begin
          if (imem_ack) begin
            state_d = S_REQ;
          end else begin
            state_d      = S_DRAIN;
            drain_addr_d = fetch_pc_q;
          end
        end
        S_DRAIN: state_d = imem_ack ? S_REQ : S_DRAIN;
        default: state_d = S_REQ;
      endcase
    end else begin
      // Bubble only when decode can take it; under stall every output bit holds.
      if (!stall) begin
        instr_valid_d = 1'b0;
        instruction_d = NOP_INSTR;
      end
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (imem_ack) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            if (!instr_valid_q || !stall) begin
              deliver       = 1'b1;
              instruction_d = imem_rdata;
              cnt_val_d     = fetch_pc_q;
              cnt_val_pl4_d = fetch_pc_q + 32'd4;
              instr_valid_d = 1'b1;
            end else begin
              hold_instr_d = imem_rdata;
              hold_pc_d    = fetch_pc_q;
              hold_pc4_d   = fetch_pc_q + 32'd4;
              hold_valid_d = 1'b1;
              state_d      = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall && hold_valid_q) begin
            deliver       = 1'b1;
            instruction_d = hold_instr_q;
            cnt_val_d     = hold_pc_q;
            cnt_val_pl4_d = hold_pc4_q;
            instr_valid_d = 1'b1;
            hold_valid_d  = 1'b0;
            state_d       = S_REQ;
          end
        end
        S_DRAIN: begin
          if (imem_ack) state_d = S_REQ;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      fetch_pc_q    <= RESET_PC;
      drain_addr_q  <= 32'h0;
      instruction_q <= NOP_INSTR;
      cnt_val_q     <= 32'h0;
      cnt_val_pl4_q <= 32'h0;
      instr_valid_q <= 1'b0;
      hold_instr_q  <= NOP_INSTR;
      hold_pc_q     <= 32'h0;
      hold_pc4_q    <= 32'h0;
      hold_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      drain_addr_q  <= drain_addr_d;
      instruction_q <= instruction_d;
      cnt_val_q     <= cnt_val_d;
      cnt_val_pl4_q <= cnt_val_pl4_d;
      instr_valid_q <= instr_valid_d;
      hold_instr_q  <= hold_instr_d;
      hold_pc_q     <= hold_pc_d;
      hold_pc4_q    <= hold_pc4_d;
      hold_valid_q  <= hold_valid_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q + {31'h0, deliver};
    stall_count_d = stall_count_q + {31'h0, stall && instr_valid_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q <= 32'h0;
      stall_count_q <= 32'h0;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`else
  logic unused_deliver;
  assign unused_deliver = deliver;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a vector table stepped one clock per entry, then
// hand sequences for a double redirect in DRAIN and reset with a request outstanding.
module tb_instruction_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, redirect, imem_ack;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instruction, cnt_val, cnt_val_pl4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, stall_count;
`endif

  instruction_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instruction(instruction),
    .cnt_val    (cnt_val),
    .cnt_val_pl4(cnt_val_pl4),
    .instr_valid(instr_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count(fetch_count),
    .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stall, redir;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        chk;
    logic        e_req;
    logic [31:0] e_addr, e_ins, e_pc, e_pc4;
    logic        e_vld;
  } vec_t;

  localparam int NV = 36;
  vec_t vecs [NV];
  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(logic r, logic s, logic rd, logic [31:0] rp, logic a,
                              logic [31:0] d, logic c, logic eq, logic [31:0] ea,
                              logic [31:0] ei, logic [31:0] ep, logic [31:0] ep4, logic ev);
    vec_t v;
    v.rst = r; v.stall = s; v.redir = rd; v.rpc = rp; v.ack = a; v.rdata = d;
    v.chk = c; v.e_req = eq; v.e_addr = ea; v.e_ins = ei; v.e_pc = ep; v.e_pc4 = ep4;
    v.e_vld = ev;
    return v;
  endfunction

  task automatic cmp(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h, want %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic rd, input logic [31:0] rp,
                       input logic a, input logic [31:0] d);
    @(negedge clk);
    rst = r; stall = s; redirect = rd; redirect_pc = rp; imem_ack = a; imem_rdata = d;
    #1;
  endtask

  task automatic check_all(input int idx, input logic eq, input logic [31:0] ea,
                           input logic [31:0] ei, input logic [31:0] ep,
                           input logic [31:0] ep4, input logic ev);
    n_vec++;
    cmp("imem_req", idx, {31'h0, imem_req}, {31'h0, eq});
    cmp("imem_addr", idx, imem_addr, ea);
    cmp("instruction", idx, instruction, ei);
    cmp("cnt_val", idx, cnt_val, ep);
    cmp("cnt_val_pl4", idx, cnt_val_pl4, ep4);
    cmp("instr_valid", idx, {31'h0, instr_valid}, {31'h0, ev});
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_ack = 1'b0;
    imem_rdata = '0;

    // Reset, then zero-wait acks
    vecs[0]  = mk(1,0,0,0,0,0,                 0, 0,0,0,0,0,0);
    vecs[1]  = mk(1,0,0,0,0,0,                 1, 0,0,NOP,0,0,0);
    vecs[2]  = mk(0,0,0,0,1,32'hFFFF_FFFF,     1, 0,0,NOP,0,0,0);
    vecs[3]  = mk(0,0,0,0,1,32'hA000_0000,     1, 1,0,NOP,0,0,0);
    vecs[4]  = mk(0,0,0,0,1,32'hA000_0004,     1, 1,32'h4,32'hA000_0000,0,32'h4,1);
    vecs[5]  = mk(0,0,0,0,1,32'hA000_0008,     1, 1,32'h8,32'hA000_0004,32'h4,32'h8,1);
    // Ack delayed three cycles per request
    vecs[6]  = mk(0,0,0,0,0,0,                 1, 1,32'hC,32'hA000_0008,32'h8,32'hC,1);
    vecs[7]  = mk(0,0,0,0,0,0,                 1, 1,32'hC,NOP,32'h8,32'hC,0);
    vecs[8]  = mk(0,0,0,0,0,0,                 1, 1,32'hC,NOP,32'h8,32'hC,0);
    vecs[9]  = mk(0,0,0,0,1,32'hA000_000C,     1, 1,32'hC,NOP,32'h8,32'hC,0);
    vecs[10] = mk(0,0,0,0,0,0,                 1, 1,32'h10,32'hA000_000C,32'hC,32'h10,1);
    vecs[11] = mk(0,0,0,0,0,0,                 1, 1,32'h10,NOP,32'hC,32'h10,0);
    vecs[12] = mk(0,0,0,0,0,0,                 1, 1,32'h10,NOP,32'hC,32'h10,0);
    vecs[13] = mk(0,0,0,0,1,32'hA000_0010,     1, 1,32'h10,NOP,32'hC,32'h10,0);
    // Stall held five cycles, ack lands and is parked
    vecs[14] = mk(0,1,0,0,0,0,                 1, 1,32'h14,32'hA000_0010,32'h10,32'h14,1);
    vecs[15] = mk(0,1,0,0,1,32'hA000_0014,     1, 1,32'h14,32'hA000_0010,32'h10,32'h14,1);
    vecs[16] = mk(0,1,0,0,1,32'hBAD0_BAD0,     1, 0,0,32'hA000_0010,32'h10,32'h14,1);
    vecs[17] = mk(0,1,0,0,0,0,                 1, 0,0,32'hA000_0010,32'h10,32'h14,1);
    vecs[18] = mk(0,1,0,0,0,0,                 1, 0,0,32'hA000_0010,32'h10,32'h14,1);
    vecs[19] = mk(0,0,0,0,0,0,                 1, 0,0,32'hA000_0010,32'h10,32'h14,1);
    vecs[20] = mk(0,0,0,0,0,0,                 1, 1,32'h18,32'hA000_0014,32'h14,32'h18,1);
    vecs[21] = mk(0,0,0,0,1,32'hA000_0018,     1, 1,32'h18,NOP,32'h14,32'h18,0);
    // Redirect to 0x100 with request to 0x1C unacked
    vecs[22] = mk(0,0,1,32'h100,0,0,           1, 1,32'h1C,32'hA000_0018,32'h18,32'h1C,1);
    vecs[23] = mk(0,0,0,0,0,0,                 1, 1,32'h1C,NOP,32'h18,32'h1C,0);
    vecs[24] = mk(0,0,0,0,1,32'hDEAD_001C,     1, 1,32'h1C,NOP,32'h18,32'h1C,0);
    vecs[25] = mk(0,0,0,0,1,32'hA000_0100,     1, 1,32'h100,NOP,32'h18,32'h1C,0);
    vecs[26] = mk(0,0,0,0,1,32'hA000_0104,     1, 1,32'h104,32'hA000_0100,32'h100,32'h104,1);
    // Redirect to misaligned 0x202 together with stall and ack
    vecs[27] = mk(0,1,1,32'h202,1,32'hDEAD_0108, 1, 1,32'h108,32'hA000_0104,32'h104,32'h108,1);
    vecs[28] = mk(0,1,0,0,0,0,                 1, 1,32'h200,NOP,32'h104,32'h108,0);
    vecs[29] = mk(0,0,0,0,1,32'hA000_0200,     1, 1,32'h200,NOP,32'h104,32'h108,0);
    // Redirect to the top word; PC+4 wraps
    vecs[30] = mk(0,0,1,32'hFFFF_FFFC,0,0,     1, 1,32'h204,32'hA000_0200,32'h200,32'h204,1);
    vecs[31] = mk(0,0,0,0,1,32'hDEAD_0204,     1, 1,32'h204,NOP,32'h200,32'h204,0);
    vecs[32] = mk(0,0,0,0,1,32'hA00F_FFFC,     1, 1,32'hFFFF_FFFC,NOP,32'h200,32'h204,0);
    vecs[33] = mk(0,0,0,0,0,0,                 1, 1,32'h0,32'hA00F_FFFC,32'hFFFF_FFFC,32'h0,1);
    // Reset wins over a same-cycle ack
    vecs[34] = mk(1,0,0,0,1,32'hA000_0000,     1, 1,32'h0,NOP,32'hFFFF_FFFC,32'h0,0);
    vecs[35] = mk(0,0,0,0,0,0,                 1, 0,0,NOP,0,0,0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].redir, vecs[i].rpc, vecs[i].ack,
            vecs[i].rdata);
      if (vecs[i].chk)
        check_all(i, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_ins, vecs[i].e_pc,
                  vecs[i].e_pc4, vecs[i].e_vld);
`ifdef FETCH_PERF_CNT_EN
      if (i == 34) begin
        cmp("fetch_count", i, fetch_count, 32'd11);
        cmp("stall_count", i, stall_count, 32'd6);
      end
`endif
    end

    // Double redirect while draining: second target wins, old address held until ack
    drive(1,0,0,0,0,0);
    drive(0,0,0,0,0,0);
    check_all(100, 0, 32'h0, NOP, 32'h0, 32'h0, 0);
    drive(0,0,1,32'h40,0,0);
    check_all(101, 1, 32'h0, NOP, 32'h0, 32'h0, 0);
    drive(0,0,1,32'h83,0,0);
    check_all(102, 1, 32'h0, NOP, 32'h0, 32'h0, 0);
    drive(0,0,0,0,1,32'hDEAD_0000);
    check_all(103, 1, 32'h0, NOP, 32'h0, 32'h0, 0);
    drive(0,0,0,0,1,32'hC0DE_0080);
    check_all(104, 1, 32'h80, NOP, 32'h0, 32'h0, 0);
    drive(0,0,0,0,0,0);
    check_all(105, 1, 32'h84, 32'hC0DE_0080, 32'h80, 32'h84, 1);
`ifdef FETCH_PERF_CNT_EN
    cmp("fetch_count", 105, fetch_count, 32'd1);
    cmp("stall_count", 105, stall_count, 32'd0);
`endif

    // Reset with request to 0x84 outstanding; the request is abandoned
    drive(1,0,0,0,1,32'hDEAD_0084);
    drive(0,0,0,0,1,32'hDEAD_0084);
    check_all(106, 0, 32'h0, NOP, 32'h0, 32'h0, 0);
    drive(0,0,0,0,0,0);
    check_all(107, 1, 32'h0, NOP, 32'h0, 32'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
